regex_stream_ctx_ctrl: RTL and testbench
========================================

# regex_stream_ctx_ctrl

Parametrised per-stream context controller for the DPI category matchers. It sits between the packet parser and any single DFA category matcher. It saves and restores matcher state per stream ID and keeps a saturating per-stream match counter plus a global counter. It reports a per-packet match verdict. Unlike the fixed 64-stream / 11-bit wrappers, stream count, state width and counter width are parameters, and the block runs an explicit packet FSM with a ready handshake.

## Interface
- NUM_STREAMS, 64: number of stream contexts; power of two, at least 2.
- SID_W, $clog2(NUM_STREAMS): stream ID width.
- STATE_W, 11: matcher state width.
- COUNT_W, 16: width of the per-stream and global counters.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- sop  in  1  packet start; stream_id, new_stream_id and enable are sampled with it.
- stream_id  in  SID_W  stream of the packet.
- new_stream_id  in  1  force a fresh context (state 0, counter 0).
- enable  in  1  matcher enabled for this packet.
- char_in  in  8  payload byte.
- char_in_vld  in  1  byte valid.
- eop  in  1  marks the last byte; only legal together with char_in_vld.
- ready  out  1  block can accept sop or bytes.
- m_char  out  8  byte to the matcher.
- m_char_vld  out  1  byte valid to the matcher.
- m_state_in  out  STATE_W  state to load into the matcher.
- m_state_in_vld  out  1  load strobe to the matcher.
- m_state_out  in  STATE_W  current matcher state.
- m_accept  in  1  matcher accept; 1-cycle latency after m_char_vld.
- fired  out  1  sticky match flag for the current packet.
- pkt_done  out  1  1-cycle pulse when the verdict is final.
- pkt_match  out  1  verdict; valid while pkt_done is high.
- cnt_rd_id  in  SID_W  counter read address.
- cnt_rd_data  out  COUNT_W  per-stream count, registered, 1-cycle latency.
- total_count  out  COUNT_W  saturating count of matched packets across all streams.

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, COMMIT.
- IDLE
  - ready is 1.
  - On sop, latch stream_id and enable and go to LOAD.
  - Bytes received in IDLE are ignored.
- LOAD
  - ready is 0; clear fired.
  - If new_stream_id was set, or valid[sid] is 0: m_state_in = 0 and the count base is 0.
  - Otherwise m_state_in = state_mem[sid].
  - Pulse m_state_in_vld only if enable; then go to RUN.
- RUN
  - ready is 1.
  - If enable, forward each byte to the matcher (m_char_vld = char_in_vld).
  - If not enable, m_char_vld stays 0.
  - On eop, go to DRAIN.
  - A sop received in RUN is a protocol error: it is ignored and the cycle is counted as neither.
- DRAIN
  - ready is 0.
  - One cycle that captures the final m_accept and m_state_out.
- COMMIT
  - ready is 0.
  - If enable: state_mem[sid] <= m_state_out and valid[sid] <= 1.
  - If enable: cnt_mem[sid] <= sat(base + fired); total_count <= sat(total_count + fired).
  - Pulse pkt_done with pkt_match = fired & enable; then return to IDLE.
  - If not enable: state, counters and valid are untouched and pkt_match = 0.
- fired is set by any m_accept while enable is 1, in RUN or DRAIN.
- Saturation: counters stop at 2^COUNT_W-1 and never wrap.
- Read port
  - If valid[cnt_rd_id] is 0, cnt_rd_data reads 0.
  - Read-first: a read of sid in the COMMIT cycle returns the pre-commit value.

## Timing
- Reset state:
  - FSM in IDLE.
  - valid all 0, fired 0, pkt_done 0, pkt_match 0, total_count 0, cnt_rd_data 0.
  - m_state_in_vld 0, m_char_vld 0, ready 1.
- state_mem and cnt_mem are not reset; valid bits gate all use.
- Packet overhead: sop cycle, then LOAD (1), then RUN bytes, then DRAIN (1), then COMMIT (1).
- pkt_done arrives 2 cycles after the eop byte. The next sop is accepted the cycle after pkt_done.
- m_state_in_vld is high in the LOAD cycle; the first byte may arrive in the following cycle.
- rst_n low mid-packet: the packet is abandoned with no commit and no pkt_done, and all contexts are invalidated.
- sop together with eop in a single-byte packet is illegal; the minimum packet is sop then one byte with eop.

## Structure
- Shared package regex_ctx_pkg:
  - FSM state enum.
  - sat_inc function, parametrised on width.
- Sub-module regex_ctx_mem holds state_mem, cnt_mem and the valid vector.
  - One write port, used by COMMIT.
  - Two read ports: the LOAD context read and the counter read.
- The matcher itself stays external so that any CATEGORY_* DFA can attach.

## Test plan
- Fresh stream:
  - Stimulus: sop with sid=3 and new_stream_id=1; bytes that give 2 accepts.
  - Required: pkt_match=1, cnt[3]=1, total_count=1.
- Resume:
  - Stimulus: packet A on sid 5 ends in state 0x2A; then packet B on sid 5 with new_stream_id=0.
  - Required: m_state_in=0x2A with m_state_in_vld in B's LOAD.
- Disabled:
  - Stimulus: enable=0 on sid 5.
  - Required: m_char_vld never asserts, pkt_match=0, and state_mem[5] and cnt[5] are unchanged.
- Saturation:
  - Stimulus: COUNT_W=4; 17 matching packets on sid 0.
  - Required: cnt[0]=15 and total_count=15.
- Read collision:
  - Stimulus: cnt_rd_id=7 during the COMMIT of a matching sid-7 packet with old count 4.
  - Required: read returns 4; the next read returns 5.
- Reset mid-packet:
  - Stimulus: rst_n low during RUN on sid 2, then a packet on sid 2 with new_stream_id=0.
  - Required: m_state_in=0, and cnt_rd_data for sid 2 reads 0.

Source files
------------

// File: rtl/regex_ctx_pkg.sv
// Shared types and helpers for the per-stream regex context controller.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package regex_ctx_pkg;

    // Packet FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_COMMIT
    } ctx_state_e;

    // Widest counter the saturating helper supports
    localparam int unsigned SAT_MAX_W = 32;

    // Saturating increment of a width-bit value carried in a SAT_MAX_W container
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] val,
        input logic                 inc,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (width >= SAT_MAX_W) ? '1
                                       : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
        if (inc && (val != max_val)) begin
            return val + SAT_MAX_W'(1);
        end
        return val;
    endfunction

endpackage

// File: rtl/regex_ctx_mem.sv
// Per-stream context storage: matcher state, match counter and valid bit.
// Latency: context read combinational; counter read registered, 1 cycle, read-first.
// Backpressure: none; one write port and two read ports are always available.
module regex_ctx_mem
    import regex_ctx_pkg::*;
#(
    parameter int unsigned NUM_STREAMS = 64,
    parameter int unsigned SID_W       = $clog2(NUM_STREAMS),
    parameter int unsigned STATE_W     = 11,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [SID_W-1:0]   wr_sid_i,
    input  logic [STATE_W-1:0] wr_state_i,
    input  logic [COUNT_W-1:0] wr_cnt_i,
    input  logic [SID_W-1:0]   ctx_sid_i,
    output logic               ctx_vld_o,
    output logic [STATE_W-1:0] ctx_state_o,
    output logic [COUNT_W-1:0] ctx_cnt_o,
    input  logic [SID_W-1:0]   rd_id_i,
    output logic [COUNT_W-1:0] rd_data_o
);

    logic [STATE_W-1:0]     state_mem_q [NUM_STREAMS];
    logic [COUNT_W-1:0]     cnt_mem_q   [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_q;
    logic [COUNT_W-1:0]     rd_data_q;

    // Context read for the packet being opened; valid bit gates stale contents
    assign ctx_vld_o   = valid_q[ctx_sid_i];
    assign ctx_state_o = state_mem_q[ctx_sid_i];
    assign ctx_cnt_o   = cnt_mem_q[ctx_sid_i];
    assign rd_data_o   = rd_data_q;

    // Valid bits and the registered counter read (samples before any same-cycle write)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en_i) begin
                valid_q[wr_sid_i] <= 1'b1;
            end
            rd_data_q <= valid_q[rd_id_i] ? cnt_mem_q[rd_id_i] : '0;
        end
    end

    // Storage arrays carry no reset; the valid bits decide whether contents are used
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            state_mem_q[wr_sid_i] <= wr_state_i;
            cnt_mem_q[wr_sid_i]   <= wr_cnt_i;
        end
    end

endmodule

// File: rtl/regex_stream_ctx_ctrl.sv
// Per-stream context controller between packet parser and an external DFA matcher.
// Latency: sop -> LOAD 1 cycle; bytes pass through combinationally; pkt_done 2 cycles after eop.
// Backpressure: ready is low in LOAD, DRAIN and COMMIT; sop/bytes are only taken while ready.
module regex_stream_ctx_ctrl
    import regex_ctx_pkg::*;
#(
    parameter int unsigned NUM_STREAMS = 64,
    parameter int unsigned SID_W       = $clog2(NUM_STREAMS),
    parameter int unsigned STATE_W     = 11,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sop,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               enable,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic               eop,
    output logic               ready,
    output logic [7:0]         m_char,
    output logic               m_char_vld,
    output logic [STATE_W-1:0] m_state_in,
    output logic               m_state_in_vld,
    input  logic [STATE_W-1:0] m_state_out,
    input  logic               m_accept,
    output logic               fired,
    output logic               pkt_done,
    output logic               pkt_match,
    input  logic [SID_W-1:0]   cnt_rd_id,
    output logic [COUNT_W-1:0] cnt_rd_data,
    output logic [COUNT_W-1:0] total_count
);

    ctx_state_e         state_q;
    logic [SID_W-1:0]   sid_q;
    logic               en_q;
    logic               fired_q;
    logic               ready_q;
    logic               ld_vld_q;
    logic               done_q;
    logic               match_q;
    logic [STATE_W-1:0] ld_state_q;
    logic [STATE_W-1:0] fin_state_q;
    logic [COUNT_W-1:0] base_q;
    logic [COUNT_W-1:0] total_q;

    logic               ctx_vld;
    logic [STATE_W-1:0] ctx_state;
    logic [COUNT_W-1:0] ctx_cnt;
    logic               fresh;
    logic               wr_en;
    logic [COUNT_W-1:0] wr_cnt;
    logic               accept_hit;

    // A forced restart or a never-written stream starts from state 0 and count 0
    assign fresh      = new_stream_id | ~ctx_vld;
    assign accept_hit = m_accept & en_q;
    assign wr_en      = (state_q == ST_COMMIT) & en_q;
    assign wr_cnt     = COUNT_W'(sat_inc(SAT_MAX_W'(base_q), fired_q, COUNT_W));

    assign ready          = ready_q;
    assign m_char         = char_in;
    assign m_char_vld     = (state_q == ST_RUN) & en_q & char_in_vld;
    assign m_state_in     = ld_state_q;
    assign m_state_in_vld = ld_vld_q;
    assign fired          = fired_q;
    assign pkt_done       = done_q;
    assign pkt_match      = match_q;
    assign total_count    = total_q;

    regex_ctx_mem #(
        .NUM_STREAMS (NUM_STREAMS),
        .SID_W       (SID_W),
        .STATE_W     (STATE_W),
        .COUNT_W     (COUNT_W)
    ) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en),
        .wr_sid_i    (sid_q),
        .wr_state_i  (fin_state_q),
        .wr_cnt_i    (wr_cnt),
        .ctx_sid_i   (stream_id),
        .ctx_vld_o   (ctx_vld),
        .ctx_state_o (ctx_state),
        .ctx_cnt_o   (ctx_cnt),
        .rd_id_i     (cnt_rd_id),
        .rd_data_o   (cnt_rd_data)
    );

    // Packet FSM: context is fetched at sop so LOAD can present it from registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sid_q       <= '0;
            en_q        <= 1'b0;
            fired_q     <= 1'b0;
            ready_q     <= 1'b1;
            ld_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            ld_state_q  <= '0;
            fin_state_q <= '0;
            base_q      <= '0;
            total_q     <= '0;
        end else begin
            ld_vld_q <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sop) begin
                        sid_q      <= stream_id;
                        en_q       <= enable;
                        ld_state_q <= fresh ? '0 : ctx_state;
                        base_q     <= fresh ? '0 : ctx_cnt;
                        ld_vld_q   <= enable;
                        ready_q    <= 1'b0;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    fired_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    fired_q <= fired_q | accept_hit;
                    if (char_in_vld && eop) begin
                        ready_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    fired_q     <= fired_q | accept_hit;
                    fin_state_q <= m_state_out;
                    done_q      <= 1'b1;
                    match_q     <= (fired_q | accept_hit) & en_q;
                    state_q     <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (en_q) begin
                        total_q <= COUNT_W'(sat_inc(SAT_MAX_W'(total_q), fired_q, COUNT_W));
                    end
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regex_stream_ctx_ctrl.sv
// Bench for regex_stream_ctx_ctrl with a toy matcher and scoreboard queues.
// Latency: expectations follow load in LOAD, pkt_done 2 cycles after eop, total 1 cycle later.
// Backpressure: stimulus only drives sop/bytes while the DUT is ready.
module tb_regex_stream_ctx_ctrl;

    localparam int unsigned NS  = 16;
    localparam int unsigned SW  = 4;
    localparam int unsigned STW = 11;
    localparam int unsigned CW  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sop;
    logic [SW-1:0]  stream_id;
    logic           new_stream_id;
    logic           enable;
    logic [7:0]     char_in;
    logic           char_in_vld;
    logic           eop;
    logic           ready;
    logic [7:0]     m_char;
    logic           m_char_vld;
    logic [STW-1:0] m_state_in;
    logic           m_state_in_vld;
    logic [STW-1:0] m_state_out;
    logic           m_accept;
    logic           fired;
    logic           pkt_done;
    logic           pkt_match;
    logic [SW-1:0]  cnt_rd_id;
    logic [CW-1:0]  cnt_rd_data;
    logic [CW-1:0]  total_count;

    typedef struct {
        logic          match;
        logic [CW-1:0] total;
    } done_t;

    logic [STW-1:0] ld_q [$];
    done_t          done_q [$];
    logic [CW-1:0]  exp_total;
    int             n_vec  = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    regex_stream_ctx_ctrl #(
        .NUM_STREAMS (NS),
        .SID_W       (SW),
        .STATE_W     (STW),
        .COUNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sop            (sop),
        .stream_id      (stream_id),
        .new_stream_id  (new_stream_id),
        .enable         (enable),
        .char_in        (char_in),
        .char_in_vld    (char_in_vld),
        .eop            (eop),
        .ready          (ready),
        .m_char         (m_char),
        .m_char_vld     (m_char_vld),
        .m_state_in     (m_state_in),
        .m_state_in_vld (m_state_in_vld),
        .m_state_out    (m_state_out),
        .m_accept       (m_accept),
        .fired          (fired),
        .pkt_done       (pkt_done),
        .pkt_match      (pkt_match),
        .cnt_rd_id      (cnt_rd_id),
        .cnt_rd_data    (cnt_rd_data),
        .total_count    (total_count)
    );

    // Toy matcher: state becomes the last byte seen, accept one cycle after byte 0xFF
    always @(posedge clk) begin
        if (!rst_n) begin
            m_state_out <= '0;
            m_accept    <= 1'b0;
        end else begin
            m_accept <= m_char_vld && (m_char == 8'hFF);
            if (m_state_in_vld) begin
                m_state_out <= m_state_in;
            end else if (m_char_vld) begin
                m_state_out <= {3'b000, m_char};
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input int sid, input logic [CW-1:0] exp);
        cnt_rd_id = SW'(sid);
        @(negedge clk);
        check(nm, 32'(cnt_rd_data), 32'(exp));
    endtask

    // Drive one packet; expectations are queued for the monitor before anything is driven
    task automatic send_pkt(input int sid, input bit nw, input bit en,
                            input logic [7:0] b [4], input int n,
                            input logic [STW-1:0] exp_ld, input bit exp_match);
        done_t d;
        bit    got;
        if (en) ld_q.push_back(exp_ld);
        if (en && exp_match && (exp_total != '1)) exp_total = exp_total + 1'b1;
        d.match = exp_match;
        d.total = exp_total;
        done_q.push_back(d);
        check("ready_idle", 32'(ready), 32'd1);
        sop           = 1'b1;
        stream_id     = SW'(sid);
        new_stream_id = nw;
        enable        = en;
        @(negedge clk);
        sop           = 1'b0;
        new_stream_id = 1'b0;
        check("ready_load", 32'(ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            char_in     = b[i];
            char_in_vld = 1'b1;
            eop         = (i == n - 1);
            #1;
            check("m_char_vld", 32'(m_char_vld), 32'(en));
            @(negedge clk);
        end
        char_in_vld = 1'b0;
        eop         = 1'b0;
        got         = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (pkt_done) got = 1'b1;
            else @(negedge clk);
        end
        check("pkt_done_seen", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT strobes a load or a verdict
    initial begin
        bit            tot_pend;
        logic [CW-1:0] tot_exp;
        done_t         d;
        tot_pend = 1'b0;
        tot_exp  = '0;
        forever begin
            @(negedge clk);
            if (tot_pend) begin
                check("total_count", 32'(total_count), 32'(tot_exp));
                tot_pend = 1'b0;
            end
            if (rst_n && m_state_in_vld) begin
                if (ld_q.size() == 0) check("unexpected_load", 32'(m_state_in_vld), 32'd0);
                else check("m_state_in", 32'(m_state_in), 32'(ld_q.pop_front()));
            end
            if (rst_n && pkt_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(pkt_done), 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check("pkt_match", 32'(pkt_match), 32'(d.match));
                    tot_exp  = d.total;
                    tot_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        sop           = 1'b0;
        stream_id     = '0;
        new_stream_id = 1'b0;
        enable        = 1'b0;
        char_in       = '0;
        char_in_vld   = 1'b0;
        eop           = 1'b0;
        cnt_rd_id     = '0;
        exp_total     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",     32'(ready),          32'd1);
        check("rst_pkt_done",  32'(pkt_done),       32'd0);
        check("rst_pkt_match", 32'(pkt_match),      32'd0);
        check("rst_total",     32'(total_count),    32'd0);
        check("rst_rd_data",   32'(cnt_rd_data),    32'd0);
        check("rst_ld_vld",    32'(m_state_in_vld), 32'd0);
        check("rst_char_vld",  32'(m_char_vld),     32'd0);
        check("rst_fired",     32'(fired),          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh stream: two accepts still count as one matching packet
        send_pkt(3, 1, 1, '{8'hFF, 8'h01, 8'hFF, 8'h10}, 4, 11'h000, 1);
        check("fired_sticky", 32'(fired), 32'd1);
        rd_chk("cnt3_fresh", 3, 4'd1);
        check("total_fresh", 32'(total_count), 32'd1);

        // Resume: A leaves sid 5 in 0x2A, B must be loaded with it
        send_pkt(5, 1, 1, '{8'h11, 8'h2A, 8'h00, 8'h00}, 2, 11'h000, 0);
        send_pkt(5, 0, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 11'h02A, 1);
        rd_chk("cnt5_resume", 5, 4'd1);

        // Disabled: no bytes to matcher, no verdict, sid 5 context untouched
        send_pkt(5, 0, 0, '{8'hFF, 8'hFF, 8'h33, 8'h00}, 3, 11'h000, 0);
        rd_chk("cnt5_disabled", 5, 4'd1);
        check("total_disabled", 32'(total_count), 32'd2);
        send_pkt(5, 0, 1, '{8'h44, 8'h00, 8'h00, 8'h00}, 1, 11'h0FF, 0);

        // Read collision: bring sid 7 to 4, then read it during the commit of a match
        send_pkt(7, 1, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 11'h000, 1);
        for (int k = 0; k < 3; k++) send_pkt(7, 0, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 11'h0FF, 1);
        rd_chk("cnt7_before", 7, 4'd4);
        send_pkt(7, 0, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 11'h0FF, 1);
        check("cnt7_read_first", 32'(cnt_rd_data), 32'd4);
        @(negedge clk);
        check("cnt7_after", 32'(cnt_rd_data), 32'd5);
        check("total_collision", 32'(total_count), 32'd7);

        // Reset mid-packet: sid 2 is valid, then a packet is cut off in RUN
        send_pkt(2, 1, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 11'h000, 1);
        ld_q.push_back(11'h0FF);
        sop = 1'b1; stream_id = 4'd2; new_stream_id = 1'b0; enable = 1'b1;
        @(negedge clk);
        sop = 1'b0;
        @(negedge clk);
        char_in = 8'hFF; char_in_vld = 1'b1;
        @(negedge clk);
        char_in_vld = 1'b0;
        rst_n = 1'b0;
        done_q.delete();
        exp_total = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_total", 32'(total_count), 32'd0);
        rd_chk("cnt2_after_rst", 2, 4'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", 32'(done_q.size()), 32'd0);
        send_pkt(2, 0, 1, '{8'h01, 8'h00, 8'h00, 8'h00}, 1, 11'h000, 0);
        rd_chk("cnt2_reload", 2, 4'd0);

        // Saturation: 17 matches on sid 0 stop at 15
        for (int k = 0; k < 17; k++) begin
            send_pkt(0, (k == 0), 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1,
                     (k == 0) ? 11'h000 : 11'h0FF, 1);
        end
        rd_chk("cnt0_sat", 0, 4'd15);
        check("total_sat", 32'(total_count), 32'd15);

        repeat (3) @(negedge clk);
        check("ld_q_drained", 32'(ld_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
